// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory bus arbiter.
// The arbiter connects through the slave modport; the requester/memory side uses master.
interface mem_bus_arbiter_if #(
   parameter int unsigned N_REQ  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [N_REQ-1:0]        req_rd;
   logic [N_REQ-1:0]        req_wr;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_wdata;
   logic [N_REQ-1:0]        req_done;
   logic                    req_err;
   logic [DATA_W-1:0]       req_rdata;
   logic [ADDR_W-1:0]       mem_addr;
   logic [DATA_W-1:0]       mem_wdata;
   logic [DATA_W-1:0]       mem_rdata;
   logic                    mem_read_q;
   logic                    mem_write_q;
   logic                    mem_rd_dn;
   logic                    mem_wr_dn;
   logic                    bus_busy;
   logic [2:0]              grant_idx;

   modport slave (
      input  req_rd, req_wr, req_addr, req_wdata, mem_rdata, mem_rd_dn, mem_wr_dn,
      output req_done, req_err, req_rdata, mem_addr, mem_wdata, mem_read_q, mem_write_q,
             bus_busy, grant_idx
   );

   modport master (
      output req_rd, req_wr, req_addr, req_wdata, mem_rdata, mem_rd_dn, mem_wr_dn,
      input  req_done, req_err, req_rdata, mem_addr, mem_wdata, mem_read_q, mem_write_q,
             bus_busy, grant_idx
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving N_REQ CPU requesters single-access ownership of one memory port,
// with a per-access timeout that completes the access with an error flag.
module mem_bus_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input logic              CLK,
   input logic              RESET,
   mem_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [2:0]        r_grant_idx;
   logic [2:0]        r_last_grant;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_is_wr;
   logic              r_err;
   logic [7:0]        r_cnt;

   logic              w_pick_valid;
   logic [2:0]        w_pick_idx;
   logic              w_pick_rd;
   logic [ADDR_W-1:0] w_pick_addr;
   logic [DATA_W-1:0] w_pick_wdata;
   logic              w_hit;
   logic              w_timeout;

   // Scan from the furthest slot to the nearest so the first requester after last_grant wins;
   // a requester holding both rd and wr is granted the read first.
   always_comb begin
      w_pick_valid = 1'b0;
      w_pick_idx   = '0;
      w_pick_rd    = 1'b0;
      w_pick_addr  = '0;
      w_pick_wdata = '0;
      for (int unsigned k = N_REQ; k > 0; k--) begin
         int unsigned cand;
         cand = (32'(r_last_grant) + k) % N_REQ;
         if (|(((bus.req_rd | bus.req_wr) >> cand) & N_REQ'(1))) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = 3'(cand);
            w_pick_rd    = |((bus.req_rd >> cand) & N_REQ'(1));
            w_pick_addr  = ADDR_W'(bus.req_addr >> (cand * ADDR_W));
            w_pick_wdata = DATA_W'(bus.req_wdata >> (cand * DATA_W));
         end
      end
   end

   assign w_hit     = r_is_wr ? bus.mem_wr_dn : bus.mem_rd_dn;
   assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge CLK) begin
      if (RESET) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid) w_next_state = ACCESS;
         ACCESS:  if (w_hit || w_timeout) w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_grant_idx  <= '0;
         r_last_grant <= 3'(N_REQ - 1);
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_is_wr      <= 1'b0;
         r_err        <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_valid) begin
                  r_grant_idx <= w_pick_idx;
                  r_addr      <= w_pick_addr;
                  r_wdata     <= w_pick_wdata;
                  r_is_wr     <= !w_pick_rd;
                  r_rdata     <= '0;
                  r_err       <= 1'b0;
                  r_cnt       <= '0;
               end
            end
            ACCESS: begin
               if (w_hit) begin
                  r_rdata <= r_is_wr ? '0 : bus.mem_rdata;
                  r_err   <= 1'b0;
               end else if (w_timeout) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            DONE:    r_last_grant <= r_grant_idx;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.req_done    = '0;
      bus.req_err     = 1'b0;
      bus.req_rdata   = '0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      bus.mem_read_q  = 1'b0;
      bus.mem_write_q = 1'b0;
      bus.bus_busy    = 1'b0;
      bus.grant_idx   = r_grant_idx;
      case (r_state)
         ACCESS: begin
            bus.mem_addr    = r_addr;
            bus.mem_wdata   = r_wdata;
            bus.mem_read_q  = !r_is_wr;
            bus.mem_write_q = r_is_wr;
            bus.bus_busy    = 1'b1;
         end
         DONE: begin
            bus.req_done  = N_REQ'(1) << r_grant_idx;
            bus.req_err   = r_err;
            bus.req_rdata = r_rdata;
            bus.bus_busy  = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level model checked every cycle,
// plus hand-computed grant orders, latencies and data per scenario.
module tb_mem_bus_arbiter;
   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic CLK = 1'b0;
   logic RESET;
   always #5 CLK = ~CLK;

   mem_bus_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an owner is either absent, accessing (counting waited cycles) or completing.
   bit          m_valid = 0;
   int          m_phase;      // 0 none, 1 accessing, 2 completing
   int          m_owner;
   int          m_last;
   int          m_waited;
   bit          m_wr;
   bit          m_err;
   logic [31:0] m_addr, m_wdata, m_rdata;

   function automatic int rr_pick(input int last, input logic [N-1:0] rd, input logic [N-1:0] wr);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (rd[i] || wr[i]) return i;
      end
      return -1;
   endfunction

   always @(posedge CLK) begin
      if (RESET) begin
         m_valid = 1;
         m_phase = 0;
         m_owner = 0;
         m_last  = N - 1;
         m_err   = 0;
         m_rdata = '0;
      end else if (m_valid) begin
         if (m_phase == 0) begin
            int p;
            p = rr_pick(m_last, bus.req_rd, bus.req_wr);
            if (p >= 0) begin
               m_phase  = 1;
               m_owner  = p;
               m_wr     = !bus.req_rd[p];
               m_addr   = bus.req_addr[p*AW +: AW];
               m_wdata  = bus.req_wdata[p*DW +: DW];
               m_waited = 0;
            end
         end else if (m_phase == 1) begin
            m_waited++;
            if (m_wr ? bus.mem_wr_dn : bus.mem_rd_dn) begin
               m_phase = 2;
               m_err   = 0;
               m_rdata = m_wr ? 32'h0 : bus.mem_rdata;
            end else if (m_waited == TMO) begin
               m_phase = 2;
               m_err   = 1;
               m_rdata = '0;
            end
         end else begin
            m_last  = m_owner;
            m_phase = 0;
         end
      end
   end

   // Observations for the per-scenario literal checks.
   int          obs_rdq;
   int          obs_done_q[$];
   int          obs_addr_q[$];
   int          obs_op_q[$];
   logic        obs_err;
   logic [31:0] obs_rdata;
   logic [31:0] cur_addr;
   int          cur_op;

   task automatic clear_obs();
      obs_rdq = 0;
      obs_done_q.delete();
      obs_addr_q.delete();
      obs_op_q.delete();
      obs_err   = 1'b0;
      obs_rdata = '0;
   endtask

   logic [N-1:0] e_done;
   always @(negedge CLK) begin
      if (m_valid) begin
         e_done = (m_phase == 2) ? (N'(1) << m_owner) : '0;
         check("busy",    bus.bus_busy,    m_phase != 0);
         check("read_q",  bus.mem_read_q,  m_phase == 1 && !m_wr);
         check("write_q", bus.mem_write_q, m_phase == 1 && m_wr);
         check("addr",    bus.mem_addr,    (m_phase == 1) ? m_addr : 32'h0);
         check("wdata",   bus.mem_wdata,   (m_phase == 1) ? m_wdata : 32'h0);
         check("done",    bus.req_done,    e_done);
         check("err",     bus.req_err,     m_phase == 2 && m_err);
         check("rdata",   bus.req_rdata,   (m_phase == 2) ? m_rdata : 32'h0);
         check("grant",   bus.grant_idx,   m_owner);
      end
      if (bus.mem_read_q) obs_rdq++;
      if (bus.mem_read_q || bus.mem_write_q) begin
         cur_addr = bus.mem_addr;
         cur_op   = bus.mem_write_q;
      end
      if (bus.req_done != '0) begin
         int idx;
         idx = -1;
         for (int b = 0; b < N; b++) if (bus.req_done[b]) idx = b;
         obs_done_q.push_back(idx);
         obs_addr_q.push_back(int'(cur_addr));
         obs_op_q.push_back(cur_op);
         obs_err   = bus.req_err;
         obs_rdata = bus.req_rdata;
      end
   end

   bit auto_dn = 0;
   task automatic tick();
      @(posedge CLK);
      #2;
      if (auto_dn) begin
         bus.mem_rd_dn = bus.mem_read_q;
         bus.mem_wr_dn = bus.mem_write_q;
      end
   endtask

   task automatic wait_done(input int n, input int budget, input string tag);
      int c = 0;
      while (obs_done_q.size() < n && c < budget) begin
         tick();
         #4;
         c++;
      end
      check({tag, "_ndone"}, obs_done_q.size(), n);
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   initial begin
      int exp_own[5];
      int exp_op[3];
      RESET          = 1'b1;
      bus.req_rd     = '0;
      bus.req_wr     = '0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.mem_rdata  = '0;
      bus.mem_rd_dn  = 1'b0;
      bus.mem_wr_dn  = 1'b0;
      clear_obs();
      tick();
      tick();
      RESET = 1'b0;
      #4;
      check("rst_busy",  bus.bus_busy, 0);
      check("rst_grant", bus.grant_idx, 0);
      check("rst_done",  bus.req_done, 0);
      check("rst_rdq",   bus.mem_read_q | bus.mem_write_q, 0);

      // Single read by requester 2, memory answers in the third access cycle.
      clear_obs();
      bus.req_addr[2*AW +: AW] = 32'h10;
      bus.req_rd = 4'b0100;
      tick();
      tick();
      tick();
      bus.mem_rd_dn = 1'b1;
      bus.mem_rdata = 32'h12;
      wait_done(1, 6, "rd");
      bus.mem_rd_dn = 1'b0;
      bus.mem_rdata = '0;
      bus.req_rd    = '0;
      check("rd_rdq",   obs_rdq, 3);
      check("rd_owner", q_at(obs_done_q, 0), 2);
      check("rd_addr",  q_at(obs_addr_q, 0), 32'h10);
      check("rd_rdata", obs_rdata, 32'h12);
      check("rd_err",   obs_err, 0);

      // Timeout: requester 1 reads, memory never answers.
      clear_obs();
      bus.req_addr[1*AW +: AW] = 32'h44;
      bus.req_rd = 4'b0010;
      wait_done(1, 12, "tmo");
      bus.req_rd = '0;
      check("tmo_rdq",   obs_rdq, 4);
      check("tmo_owner", q_at(obs_done_q, 0), 1);
      check("tmo_err",   obs_err, 1);
      check("tmo_rdata", obs_rdata, 0);

      // Reset mid-write to 0x20 (requester 2 after last grant 1); afterwards requester 0 wins.
      clear_obs();
      bus.req_addr[2*AW +: AW]  = 32'h20;
      bus.req_wdata[2*DW +: DW] = 32'hDEAD;
      bus.req_addr[0*AW +: AW]  = 32'h40;
      bus.req_wdata[0*DW +: DW] = 32'hBEEF;
      bus.req_wr = 4'b0101;
      tick();
      tick();
      #4;
      check("mid_wq",   bus.mem_write_q, 1);
      check("mid_addr", bus.mem_addr, 32'h20);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      bus.mem_wr_dn = 1'b1;
      #4;
      check("rst2_wq",   bus.mem_write_q, 0);
      check("rst2_busy", bus.bus_busy, 0);
      check("rst2_done", bus.req_done, 0);
      tick();
      bus.mem_wr_dn = 1'b0;
      auto_dn = 1;
      wait_done(1, 10, "rst2a");
      bus.req_wr = 4'b0100;
      wait_done(2, 10, "rst2b");
      bus.req_wr = '0;
      auto_dn = 0;
      bus.mem_wr_dn = 1'b0;
      check("rst2_own0",  q_at(obs_done_q, 0), 0);
      check("rst2_addr0", q_at(obs_addr_q, 0), 32'h40);
      check("rst2_own1",  q_at(obs_done_q, 1), 2);
      check("rst2_addr1", q_at(obs_addr_q, 1), 32'h20);

      // Fairness: all four write continuously from reset, memory answers at once.
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      clear_obs();
      for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = 32'h100 + i;
      bus.req_wr = 4'b1111;
      auto_dn = 1;
      wait_done(5, 40, "fair");
      bus.req_wr = '0;
      auto_dn = 0;
      bus.mem_wr_dn = 1'b0;
      exp_own = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) check($sformatf("fair_own%0d", i), q_at(obs_done_q, i), exp_own[i]);

      // Requester 0 reads and writes; requester 2 writes: read, then 2, then 0's write.
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      clear_obs();
      bus.req_addr[0*AW +: AW] = 32'h200;
      bus.req_addr[2*AW +: AW] = 32'h220;
      bus.mem_rdata = 32'h5A5A;
      bus.req_rd = 4'b0001;
      bus.req_wr = 4'b0101;
      auto_dn = 1;
      wait_done(1, 10, "rw1");
      bus.req_rd = '0;
      wait_done(2, 10, "rw2");
      bus.req_wr = 4'b0001;
      wait_done(3, 10, "rw3");
      bus.req_wr = '0;
      auto_dn = 0;
      bus.mem_rd_dn = 1'b0;
      bus.mem_wr_dn = 1'b0;
      bus.mem_rdata = '0;
      exp_own[0] = 0; exp_own[1] = 2; exp_own[2] = 0;
      exp_op = '{0, 1, 1};
      for (int i = 0; i < 3; i++) begin
         check($sformatf("rw_own%0d", i), q_at(obs_done_q, i), exp_own[i]);
         check($sformatf("rw_op%0d", i),  q_at(obs_op_q, i),   exp_op[i]);
      end

      // Wrong-type done: wr_dn during requester 3's read is ignored.
      clear_obs();
      bus.req_addr[3*AW +: AW] = 32'h30;
      bus.req_rd = 4'b1000;
      tick();
      tick();
      bus.mem_wr_dn = 1'b1;
      tick();
      bus.mem_wr_dn = 1'b0;
      tick();
      bus.mem_rd_dn = 1'b1;
      bus.mem_rdata = 32'hABCD;
      wait_done(1, 6, "wt");
      bus.mem_rd_dn = 1'b0;
      bus.mem_rdata = '0;
      bus.req_rd    = '0;
      check("wt_rdq",   obs_rdq, 3);
      check("wt_owner", q_at(obs_done_q, 0), 3);
      check("wt_addr",  q_at(obs_addr_q, 0), 32'h30);
      check("wt_rdata", obs_rdata, 32'hABCD);
      check("wt_err",   obs_err, 0);

      repeat (3) tick();
      #4;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
